// File: rtl/mem_access_unit.sv
// Initiator for the shared instruction/data memory port of the multi-cycle CPU.
// Ports: req_* (request in, ready out), resp_* (response pulse), mem_* (memory pins).
module mem_access_unit #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RMW_RD,
        WR,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [15:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mwdata_q, mwdata_d;

    logic        accept;
    logic        req_err;
    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] load_val;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [31:0] merged;
    logic [31:0] word_addr;

    assign req_ready = (state_q == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign word_addr = {addr_q[31:2], 2'b00};

    // Checks in priority order; any hit means no memory traffic.
    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'd3)
            req_err = 1'b1;
        else if (req_size == 2'd1 && req_addr[0])
            req_err = 1'b1;
        else if (req_size == 2'd2 && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
        else if (req_addr >= MEM_BYTES)
            req_err = 1'b1;
    end

    // Halves are always 2-aligned here, so 8*addr[1:0] is the lane
    // offset for both byte and half accesses.
    assign shamt   = {addr_q[1:0], 3'b000};
    assign shifted = mem_rdata >> shamt;

    always_comb begin
        case (size_q)
            2'd0:    load_val = {{24{signed_q & shifted[7]}}, shifted[7:0]};
            2'd1:    load_val = {{16{signed_q & shifted[15]}}, shifted[15:0]};
            default: load_val = mem_rdata;
        endcase
    end

    always_comb begin
        if (size_q == 2'd0) begin
            lane_mask = 32'h0000_00FF << shamt;
            lane_data = {24'h0, wdata_q[7:0]} << shamt;
        end else begin
            lane_mask = 32'h0000_FFFF << shamt;
            lane_data = {16'h0, wdata_q} << shamt;
        end
    end

    assign merged = (mem_rdata & ~lane_mask) | (lane_data & lane_mask);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        signed_d  = signed_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        mwdata_d  = mwdata_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 32'h0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d   = req_addr;
                    size_d   = req_size;
                    signed_d = req_signed;
                    wdata_d  = req_wdata[15:0];
                    mwdata_d = req_wdata;
                    err_d    = req_err;
                    rdata_d  = 32'h0;
                    if (req_err)
                        state_d = RESP;
                    else if (!req_write)
                        state_d = RD;
                    else if (req_size == 2'd2)
                        state_d = WR;
                    else
                        state_d = RMW_RD;
                end
            end
            RD: begin
                mem_read = 1'b1;
                mem_addr = word_addr;
                rdata_d  = load_val;
                state_d  = RESP;
            end
            RMW_RD: begin
                mem_read = 1'b1;
                mem_addr = word_addr;
                mwdata_d = merged;
                state_d  = WR;
            end
            WR: begin
                mem_write = 1'b1;
                mem_addr  = word_addr;
                state_d   = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= 32'h0;
            size_q   <= 2'd0;
            signed_q <= 1'b0;
            wdata_q  <= 16'h0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
            mwdata_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            mwdata_q <= mwdata_d;
        end
    end

    assign resp_err   = (state_q == RESP) && err_q;
    assign resp_rdata = rdata_q;
    assign mem_wdata  = mwdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a word-wide memory model.
// Stimulus pushes expectations; a negedge monitor pops them on resp_valid.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    mem_access_unit #(.MEM_BYTES(1024)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = 8'h0;
    logic [31:0] pl_val = 32'h0;

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_idx] <= pl_val;
        else if (mem_write)
            mem[mem_addr[9:2]] <= mem_wdata;
    end

    assign mem_rdata = mem[mem_addr[9:2]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        int          acc;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;
    int last_resp_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: counts memory activity per transaction, checks on resp_valid.
    int nrd = 0;
    int nwr = 0;
    logic [31:0] wa = 32'h0;
    logic [31:0] wd = 32'h0;

    always @(negedge clk) begin
        if (reset) begin
            nrd = 0;
            nwr = 0;
        end else begin
            if (mem_read && mem_write)
                chk("rd_wr_overlap", 32'd1, 32'd0);
            if (mem_read) nrd++;
            if (mem_write) begin
                nwr++;
                wa = mem_addr;
                wd = mem_wdata;
            end
            if (resp_valid) begin
                exp_t e;
                last_resp_cyc = cyc;
                if (q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("latency", cyc - e.acc, e.lat);
                    chk("mem_read_cycles", nrd, e.nrd);
                    chk("mem_write_cycles", nwr, e.nwr);
                    if (e.nwr > 0) begin
                        chk("write_addr", wa, e.waddr);
                        chk("write_data", wd, e.wdata);
                    end
                end
                nrd = 0;
                nwr = 0;
            end
        end
    end

    task automatic preload(input logic [7:0] idx, input logic [31:0] v);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_val = v;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic w, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a,
                         input logic [31:0] wdat, input exp_t e,
                         input bit hold, input bit push, input bit gap);
        bit ok = 0;
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wdat;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (req_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        if (gap)
            chk("accept_gap", cyc - last_resp_cyc, 32'd1);
        e.acc = cyc;
        if (push) q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    function automatic exp_t mk(input logic err, input logic [31:0] rd,
                                input int lat, input int r, input int w,
                                input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.err = err; e.rdata = rd; e.lat = lat;
        e.nrd = r; e.nwr = w; e.waddr = a; e.wdata = d; e.acc = 0;
        return e;
    endfunction

    task automatic ld(input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] rd,
                      input bit hold, input bit gap);
        issue(1'b0, sz, sg, a, 32'h0, mk(1'b0, rd, 2, 1, 0, 0, 0),
              hold, 1, gap);
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wdat, input logic [31:0] mw);
        if (sz == 2'd2)
            issue(1'b1, sz, 1'b0, a, wdat,
                  mk(1'b0, 0, 2, 0, 1, {a[31:2], 2'b00}, mw), 0, 1, 0);
        else
            issue(1'b1, sz, 1'b0, a, wdat,
                  mk(1'b0, 0, 3, 1, 1, {a[31:2], 2'b00}, mw), 0, 1, 0);
    endtask

    task automatic bad(input logic w, input logic [1:0] sz,
                       input logic [31:0] a);
        issue(w, sz, 1'b0, a, 32'hFFFF_FFFF, mk(1'b1, 0, 1, 0, 0, 0, 0),
              0, 1, 0);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        preload(8'd64, 32'h0);
        preload(8'd255, 32'h0);
        preload(8'd32, 32'h1122_3344);
        preload(8'd16, 32'h80F0_007F);
        preload(8'd8, 32'hCAFE_F00D);
        #1;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_rw", {30'h0, mem_read, mem_write}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("idle_req_ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);

        st(2'd2, 32'h100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        ld(2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF, 0, 0);
        st(2'd0, 32'h81, 32'h0000_00AA, 32'h1122_AA44);
        st(2'd1, 32'h82, 32'h1234_BEEF, 32'hBEEF_AA44);
        ld(2'd2, 1'b0, 32'h80, 32'hBEEF_AA44, 0, 0);

        ld(2'd0, 1'b1, 32'h40, 32'h0000_007F, 0, 0);
        ld(2'd0, 1'b1, 32'h43, 32'hFFFF_FF80, 0, 0);
        ld(2'd0, 1'b0, 32'h43, 32'h0000_0080, 0, 0);
        ld(2'd0, 1'b1, 32'h41, 32'h0000_0000, 0, 0);
        ld(2'd1, 1'b0, 32'h42, 32'h0000_80F0, 0, 0);
        ld(2'd1, 1'b1, 32'h42, 32'hFFFF_80F0, 0, 0);
        ld(2'd1, 1'b1, 32'h40, 32'h0000_007F, 0, 0);

        bad(1'b0, 2'd1, 32'h41);
        bad(1'b0, 2'd2, 32'h42);
        bad(1'b0, 2'd3, 32'h0);
        bad(1'b0, 2'd2, 32'h400);
        bad(1'b1, 2'd0, 32'h400);
        bad(1'b1, 2'd2, 32'h3FE);
        st(2'd0, 32'h3FF, 32'h0000_005A, 32'h5A00_0000);
        ld(2'd0, 1'b0, 32'h3FF, 32'h0000_005A, 0, 0);

        // Reset lands while the sub-word store sits in RMW_RD.
        issue(1'b1, 2'd0, 1'b0, 32'h21, 32'h11,
              mk(1'b0, 0, 3, 1, 1, 0, 0), 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_ready_low", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_ready_after", {31'h0, req_ready}, 32'h1);
        repeat (4) @(negedge clk);
        chk("midrst_no_write", mem[8], 32'hCAFE_F00D);

        ld(2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF, 1, 0);
        ld(2'd2, 1'b0, 32'h80, 32'hBEEF_AA44, 1, 1);
        ld(2'd2, 1'b0, 32'h40, 32'h80F0_007F, 1, 1);
        ld(2'd0, 1'b0, 32'h3FF, 32'h0000_005A, 0, 1);

        for (int i = 0; i < 20; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        chk("pending_responses", q.size(), 32'd0);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
